aximm_wr_buf: RTL
=================

Name: aximm_wr_buf

Overview:
Write-data buffer directly upstream of the AXI-MM write valid controller. Accepts W-channel beats through a valid/ready handshake and stores them in a synchronous circular FIFO. Exposes the fifo_empty/fifo_rden read interface that the controller consumes, with read data registered one cycle after fifo_rden. Also provides fill level, almost-full, and sticky error flags for status/CSR logic.

Parameters:
DWIDTH, 64, W-channel data width in bits
DEPTH, 16, FIFO entries; power of 2, minimum 4
AWIDTH, $clog2(DEPTH), pointer width (derived; do not override)
AFULL_TH, 12, almost_full asserts when fill_level >= AFULL_TH; range 1..DEPTH

Ports:
clk  in  1  single clock for all logic
rst_n  in  1  asynchronous active-low reset
s_wvalid  in  1  upstream beat valid
s_wready  out  1  buffer can accept a beat
s_wdata  in  DWIDTH  beat data
s_wlast  in  1  last beat of burst; stored alongside data
fifo_rden  in  1  read strobe from the downstream valid controller
fifo_empty  out  1  no stored entries
fifo_rdata  out  DWIDTH  read data, valid the cycle after an accepted read
fifo_rlast  out  1  stored wlast paired with fifo_rdata
fill_level  out  AWIDTH+1  current entry count, 0..DEPTH
almost_full  out  1  fill_level >= AFULL_TH
ovf_err  out  1  sticky: write attempted while full
udf_err  out  1  sticky: fifo_rden asserted while empty
clr_err  in  1  synchronous clear of ovf_err and udf_err

Behaviour:
- Reset is asynchronous, active-low. Ready is "Already decided": one clock; reset is asynchronous and active-low, with ports named clk and rst_n.
- Reset values: pointers = 0, fill_level = 0, fifo_empty = 1, s_wready = 1, almost_full = 0, fifo_rdata = 0, fifo_rlast = 0, ovf_err = 0, udf_err = 0. Memory contents are not reset.
- Storage: DEPTH x (DWIDTH+1) array, circular, with wr_ptr and rd_ptr each AWIDTH bits. Pointers wrap DEPTH-1 -> 0 naturally.
- Write accept (wr_en) = s_wvalid & s_wready. On wr_en, {s_wlast, s_wdata} is written at wr_ptr and wr_ptr increments.
- s_wready = (fill_level != DEPTH). It is registered-state-derived and has no combinational path from any input.
- Read accept (rd_en) = fifo_rden & ~fifo_empty. On rd_en, fifo_rdata/fifo_rlast <= mem[rd_ptr] and rd_ptr increments. Without rd_en, fifo_rdata and fifo_rlast hold their values.
- Latency:
  - A beat written at edge N deasserts fifo_empty after edge N (visible during cycle N+1).
  - fifo_rden sampled at edge M produces data valid after edge M.
- Occupancy: fill_level updates every cycle by +wr_en - rd_en. If both occur in the same cycle, fill_level is unchanged.
- fifo_empty = (fill_level == 0). almost_full = (fill_level >= AFULL_TH).
- Boundary conditions:
  - Full: s_wready = 0, so no write can occur. s_wvalid=1 while full sets ovf_err and the beat is not stored. Upstream must hold the beat per the handshake.
  - Empty: fifo_rden=1 sets udf_err; pointers, data and fill_level are unchanged.
  - Write into an empty FIFO with fifo_rden in the same cycle: the read is ignored and udf_err is set. There is no fall-through.
  - Full with read and write in the same cycle: the write is blocked because s_wready=0; the read proceeds and fill_level becomes DEPTH-1.
  - clr_err together with a new error in the same cycle: the error wins and the flag stays 1.
- Reset asserted mid-burst: all state returns to reset values immediately and buffered beats are discarded.

Decomposition:
- Shared package aximm_pkg holds:
  - AXIMM_DWIDTH_DEF = 64
  - AXIMM_BUF_DEPTH_DEF = 16
  - a wbeat type {last, data} used by both this block and the write valid controller.
- One natural sub-module: aximm_buf_ram, a simple dual-port register array (one write port, one registered read port).
- Pointer, occupancy and flag logic remain in aximm_wr_buf.

Test Plan:
1. Reset, then write 3 beats (0xA1, 0xA2, 0xA3 with last on the 3rd) -> fill_level=3, fifo_empty=0 one cycle after the 1st write; three fifo_rden pulses return A1, A2, A3 each one cycle later, fifo_rlast=1 only with A3, fifo_empty=1 afterwards.
2. Hold s_wvalid=1 for 20 cycles with no reads (DEPTH=16) -> s_wready drops after 16 accepts, almost_full=1 from fill_level 12, ovf_err=1 on the first blocked cycle; fill_level stays 16.
3. At full, assert fifo_rden and s_wvalid for 1 cycle -> fill_level=15, s_wready=1 next cycle, oldest data read out.
4. Continuous simultaneous read and write for 40 cycles at fill_level=5 -> fill_level constant at 5, data emerges in order across pointer wrap, no error flags set.
5. fifo_rden while empty, then clr_err -> udf_err=1 the next cycle and 0 after clr_err; rd_ptr and fifo_rdata unchanged.
6. Deassert rst_n asynchronously mid-burst at fill_level=7 -> fill_level=0, fifo_empty=1, s_wready=1 with no clock edge needed; subsequent writes start at entry 0.

Source files
------------

// File: rtl/aximm_pkg.sv
//------------------------------------------------------------------------------
// aximm_pkg : shared AXI-MM write-path types and defaults
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package aximm_pkg;

  localparam int AXIMM_DWIDTH_DEF    = 64;
  localparam int AXIMM_BUF_DEPTH_DEF = 16;

  typedef struct packed {
    logic                        last;
    logic [AXIMM_DWIDTH_DEF-1:0] data;
  } wbeat_t;

  function automatic int beat_width(input int dwidth);
    return dwidth + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aximm_buf_ram.sv
//------------------------------------------------------------------------------
// aximm_buf_ram : register array, one write port, one registered read port
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module aximm_buf_ram
  import aximm_pkg::*;
#(
  parameter int WIDTH  = beat_width(AXIMM_DWIDTH_DEF),
  parameter int DEPTH  = AXIMM_BUF_DEPTH_DEF,
  parameter int AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic              re_i,
  input  logic [AWIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]  rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage is intentionally left unreset so it maps onto plain flops/LUTRAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/aximm_wr_buf.sv
//------------------------------------------------------------------------------
// aximm_wr_buf : W-channel beat FIFO feeding the AXI-MM write valid controller
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module aximm_wr_buf
  import aximm_pkg::*;
#(
  parameter int DWIDTH   = AXIMM_DWIDTH_DEF,
  parameter int DEPTH    = AXIMM_BUF_DEPTH_DEF,
  parameter int AWIDTH   = $clog2(DEPTH),
  parameter int AFULL_TH = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_wvalid,
  output logic              s_wready,
  input  logic [DWIDTH-1:0] s_wdata,
  input  logic              s_wlast,
  input  logic              fifo_rden,
  output logic              fifo_empty,
  output logic [DWIDTH-1:0] fifo_rdata,
  output logic              fifo_rlast,
  output logic [AWIDTH:0]   fill_level,
  output logic              almost_full,
  output logic              ovf_err,
  output logic              udf_err,
  input  logic              clr_err
);

  localparam logic [AWIDTH:0] FULL_LVL  = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AFULL_LVL = (AWIDTH+1)'(AFULL_TH);

  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   fill_q,   fill_d;
  logic              ovf_q,    ovf_d;
  logic              udf_q,    udf_d;
  logic              wr_en,    rd_en;
  logic [DWIDTH:0]   ram_rdata;

  // Status flags depend only on the registered count, never on inputs.
  assign s_wready    = (fill_q != FULL_LVL);
  assign fifo_empty  = (fill_q == '0);
  assign almost_full = (fill_q >= AFULL_LVL);

  assign wr_en = s_wvalid & s_wready;
  assign rd_en = fifo_rden & ~fifo_empty;

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    fill_d   = fill_q;
    case ({wr_en, rd_en})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
    // A fresh error in the same cycle as clr_err keeps the flag set.
    ovf_d = (ovf_q & ~clr_err) | (s_wvalid & ~s_wready);
    udf_d = (udf_q & ~clr_err) | (fifo_rden & fifo_empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  aximm_buf_ram #(
    .WIDTH  (DWIDTH + 1),
    .DEPTH  (DEPTH),
    .AWIDTH (AWIDTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i ({s_wlast, s_wdata}),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  assign fifo_rdata = ram_rdata[DWIDTH-1:0];
  assign fifo_rlast = ram_rdata[DWIDTH];
  assign fill_level = fill_q;
  assign ovf_err    = ovf_q;
  assign udf_err    = udf_q;

endmodule

`default_nettype wire
